uart_word_rx: RTL and testbench
===============================

Name: uart_word_rx

Overview:
- Serial receive front-end feeding the 32-bit receive FIFO.
- Deserialises 8N1 UART bytes from the `rx` pin and packs four consecutive bytes into one 32-bit word, little-endian.
- Presents each completed word on `out_interface` with a single-cycle `valid_out_interface` strobe, which is the FIFO write port.
- No backpressure: the FIFO accepts every strobe.

Parameters:
- CLK_DIV, 434, clock cycles per UART bit (50 MHz / 115200). Legal range 4..65535.
- DIV_W, 16, width of the baud counter. Must satisfy 2^DIV_W > CLK_DIV.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous UART serial input; idle high.
- out_interface  output  32  last completed word; byte0 in [7:0] … byte3 in [31:24].
- valid_out_interface  output  1  one-cycle strobe; `out_interface` holds a new word in the same cycle.
- frame_err  output  1  one-cycle strobe on a bad stop bit (or bad parity, see Optional Feature).
- busy  output  1  high whenever FSM is not IDLE or a partial word is held (byte_cnt != 0).

Behaviour:
- **Reset (sync, active-high).** Applies on any clk edge with reset=1, including mid-frame and mid-word.
  - Values: sync flops=1, state=IDLE, baud_cnt=0, bit_cnt=0, byte_cnt=0, shift=0, out_interface=0, valid_out_interface=0, frame_err=0, busy=0.
  - Partial word is discarded.
- **Input synchronisation.** `rx` passes through a 2-flop synchroniser (reset value 1). The FSM sees only `rx_s`, 2 cycles late.
- **States.** IDLE, START, DATA, STOP (plus PARITY with the option), WAIT_IDLE.
- **IDLE.** `rx_s`==0 → START, baud_cnt=0.
- **START.** Count to CLK_DIV/2 - 1 (integer divide), then sample `rx_s`.
  - 0 → DATA, baud_cnt=0, bit_cnt=0.
  - 1 → IDLE (glitch rejected, no strobe).
- **DATA.** Every CLK_DIV cycles (baud_cnt reaches CLK_DIV-1, then wraps to 0), sample `rx_s` into shift, LSB first. After 8 samples (bit_cnt 7) → STOP.
- **STOP.** After CLK_DIV cycles, sample `rx_s`.
  - 1 → byte accepted, → IDLE.
  - 0 → frame_err pulses next cycle, byte discarded, byte_cnt unchanged, → WAIT_IDLE.
- **WAIT_IDLE.** Stay until `rx_s`==1, then → IDLE. This handles break conditions.
- **Byte packing.**
  - Accepted byte is written to word_reg[8*byte_cnt+7 : 8*byte_cnt]; byte_cnt increments modulo 4.
  - When byte_cnt was 3: `out_interface` ← assembled word and `valid_out_interface`=1 for exactly one cycle, the cycle after the stop sample. byte_cnt wraps to 0.
- **Output stability.** `out_interface` changes only on a word completion or reset. `valid_out_interface` and `frame_err` are never high in the same cycle.
- **Latency.** Stop-bit sample edge → strobe: 1 cycle. `rx` falling edge → start sample: 2 + CLK_DIV/2 cycles.
- **Back-to-back frames.** A start bit immediately after the stop sample is detected normally. The FSM is in IDLE one cycle after the stop sample, within the stop bit's second half.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- **Defined:**
  - Frame is 8E1; PARITY state is inserted between DATA and STOP and sampled after CLK_DIV cycles.
  - Even-parity mismatch (XOR of 8 data bits and parity bit ≠ 0) → frame_err pulse and byte discarded, evaluated at the stop sample.
  - Stop=0 also → frame_err. Only one frame_err pulse per frame.
- **Undefined:** 8N1, PARITY state and logic absent.

Test Plan:
- CLK_DIV=8; send 0x11, 0x22, 0x33, 0x44 back-to-back → single `valid_out_interface` pulse, `out_interface`=0x44332211, 1 cycle after 4th stop sample; `busy`=0 afterwards.
- Send 8 bytes 0x00..0x07 → two strobes, words 0x03020100 then 0x07060504; `out_interface` stable between strobes.
- 3-cycle low glitch on `rx` (shorter than CLK_DIV/2) → no strobe, no `frame_err`, state returns to IDLE.
- Byte 0xA5 with stop bit 0 held low for 20 bit-times → one `frame_err` pulse, byte_cnt unchanged. Then send 4 good bytes 0x01..0x04 → `out_interface`=0x04030201.
- Send 2 bytes, assert reset 1 cycle mid-third frame, then send 0xDE, 0xAD, 0xBE, 0xEF → `out_interface`=0xEFBEADDE. No stale bytes present.
- With UART_RX_PARITY_EN: 0x03 with parity 1 → `frame_err`; 0x03 with parity 0 → accepted.

Source files
------------

// File: rtl/uart_word_rx.sv
// uart_word_rx
//   UART receive front-end that deserialises 8N1 bytes from the rx pin and
//   packs four consecutive bytes, little-endian, into one 32-bit word for the
//   receive FIFO write port.
//
//   Optional feature: define UART_RX_PARITY_EN for 8E1 framing. A PARITY state
//   is inserted between DATA and STOP, and an even-parity mismatch raises
//   frame_err.
//
// Parameters
//   CLK_DIV : clock cycles per UART bit (4..65535)
//   DIV_W   : baud counter width, 2**DIV_W > CLK_DIV
//
// Ports
//   clk                 : system clock, rising edge
//   reset               : synchronous active-high reset
//   rx                  : asynchronous serial input, idle high
//   out_interface       : last completed word, byte0 in [7:0]
//   valid_out_interface : one-cycle strobe marking a new word
//   frame_err           : one-cycle strobe on a bad stop or parity bit
//   busy                : frame in progress or partial word held
module uart_word_rx #(
  parameter int CLK_DIV = 434,
  parameter int DIV_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [31:0] out_interface,
  output logic        valid_out_interface,
  output logic        frame_err,
  output logic        busy
);

  localparam logic [DIV_W-1:0] HALF_M1 = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] FULL_M1 = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [1:0]       byte_cnt;
  logic [7:0]       shift;
  logic [23:0]      word_reg;
  logic             rx_sync_p0;
  logic             rx_sync_p1;
  logic             rx_s;
  logic             byte_ok;

`ifdef UART_RX_PARITY_EN
  logic             par_bit;

  // Even parity: the data bits together with the parity bit XOR to zero.
  function automatic logic parity_bad(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  assign byte_ok = rx_s && !parity_bad(shift, par_bit);
`else
  assign byte_ok = rx_s;
`endif

  assign rx_s = rx_sync_p1;
  assign busy = (state != S_IDLE) || (byte_cnt != 2'd0);

  // Stage p0/p1: two-flop synchroniser for the asynchronous rx pin
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= rx;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  // Receive FSM, byte packing and registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= S_IDLE;
      baud_cnt            <= '0;
      bit_cnt             <= '0;
      byte_cnt            <= '0;
      shift               <= '0;
      out_interface       <= '0;
      valid_out_interface <= 1'b0;
      frame_err           <= 1'b0;
    end else begin
      valid_out_interface <= 1'b0;
      frame_err           <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state    <= S_START;
            baud_cnt <= '0;
          end
        end
        S_START: begin
          // Mid-start-bit check rejects short low glitches.
          if (baud_cnt == HALF_M1) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? S_IDLE : S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_cnt == FULL_M1) begin
            baud_cnt <= '0;
            shift    <= {rx_s, shift[7:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (baud_cnt == FULL_M1) begin
            baud_cnt <= '0;
            par_bit  <= rx_s;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (baud_cnt == FULL_M1) begin
            baud_cnt <= '0;
            if (byte_ok) begin
              byte_cnt <= byte_cnt + 1'b1;
              case (byte_cnt)
                2'd0: word_reg[7:0]   <= shift;
                2'd1: word_reg[15:8]  <= shift;
                2'd2: word_reg[23:16] <= shift;
                default: begin
                  out_interface       <= {shift, word_reg};
                  valid_out_interface <= 1'b1;
                end
              endcase
            end else begin
              frame_err <= 1'b1;
            end
            // A low stop bit means a break may be in progress; wait it out.
            state <= rx_s ? S_IDLE : S_WAIT_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_rx.sv
// Testbench for uart_word_rx: randomized and directed UART frames, with a
// byte-list reference model feeding a scoreboard checked by a monitor.
module tb_uart_word_rx;

  localparam int CLK_DIV = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] out_interface;
  logic        valid_out_interface;
  logic        frame_err;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int stab_viol = 0;
  int both_viol = 0;

  logic [31:0] exp_words[$];
  logic [7:0]  pend[$];
  int          exp_err = 0;
  logic [31:0] last_word = '0;

  uart_word_rx #(.CLK_DIV(CLK_DIV), .DIV_W(16)) dut (
    .clk                 (clk),
    .reset               (reset),
    .rx                  (rx),
    .out_interface       (out_interface),
    .valid_out_interface (valid_out_interface),
    .frame_err           (frame_err),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference model: good bytes accumulate; every fourth one forms a word.
  task automatic model_frame(input logic [7:0] d, input bit good);
    logic [31:0] w;
    if (!good) begin
      exp_err++;
    end else begin
      pend.push_back(d);
      if (pend.size() == 4) begin
        w = 32'(pend[0]) + (32'(pend[1]) << 8) + (32'(pend[2]) << 16) + (32'(pend[3]) << 24);
        exp_words.push_back(w);
        pend.delete();
      end
    end
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (CLK_DIV) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_bad,
                            input int hold_bits);
    model_frame(d, stop_ok && !par_bad);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_time((^d) ^ par_bad);
`endif
    bit_time(stop_ok);
    if (!stop_ok) begin
      repeat (hold_bits) bit_time(1'b0);
      bit_time(1'b1);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pend.delete();
  endtask

  // Monitor: compares every DUT strobe against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      last_word = '0;
    end else begin
      if (valid_out_interface && frame_err) both_viol++;
      if (valid_out_interface) begin
        tests++;
        if (exp_words.size() == 0) begin
          fails++;
          $display("FAIL word_strobe: got unexpected word %h required no strobe", out_interface);
        end else begin
          logic [31:0] w;
          w = exp_words.pop_front();
          if (out_interface !== w) begin
            fails++;
            $display("FAIL word_value: got %h required %h", out_interface, w);
          end
        end
        last_word = out_interface;
      end else if (out_interface !== last_word) begin
        stab_viol++;
      end
      if (frame_err) begin
        tests++;
        if (exp_err == 0) begin
          fails++;
          $display("FAIL frame_err: got unexpected pulse required none");
        end else begin
          exp_err--;
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_out", out_interface, 32'h0);
    check("reset_valid", 32'(valid_out_interface), 32'h0);
    check("reset_ferr", 32'(frame_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    // Back-to-back four bytes
    send_frame(8'h11, 1, 0, 0);
    send_frame(8'h22, 1, 0, 0);
    send_frame(8'h33, 1, 0, 0);
    send_frame(8'h44, 1, 0, 0);
    tick();
    check("word1_out", out_interface, 32'h44332211);
    check("word1_busy", 32'(busy), 32'h0);

    // Two words back-to-back
    for (int i = 0; i < 8; i++) send_frame(8'(i), 1, 0, 0);
    tick();
    check("word3_out", out_interface, 32'h07060504);

    // Short low glitch must be rejected
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (3 * CLK_DIV) tick();
    check("glitch_busy", 32'(busy), 32'h0);

    // Bad stop bit with a long break, then a full good word
    send_frame(8'hA5, 0, 0, 20);
    bit_time(1'b1);
    check("break_busy", 32'(busy), 32'h0);
    send_frame(8'h01, 1, 0, 0);
    send_frame(8'h02, 1, 0, 0);
    send_frame(8'h03, 1, 0, 0);
    send_frame(8'h04, 1, 0, 0);
    tick();
    check("after_err_out", out_interface, 32'h04030201);

    // Reset in the middle of the third frame discards the partial word
    send_frame(8'h55, 1, 0, 0);
    send_frame(8'h66, 1, 0, 0);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    pulse_reset();
    rx = 1'b1;
    repeat (12 * CLK_DIV) tick();
    check("midreset_busy", 32'(busy), 32'h0);
    check("midreset_out", out_interface, 32'h0);
    send_frame(8'hDE, 1, 0, 0);
    send_frame(8'hAD, 1, 0, 0);
    send_frame(8'hBE, 1, 0, 0);
    send_frame(8'hEF, 1, 0, 0);
    tick();
    check("post_reset_out", out_interface, 32'hEFBEADDE);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1, 1, 0);
    send_frame(8'h03, 1, 0, 0);
    send_frame(8'h10, 1, 0, 0);
    send_frame(8'h20, 1, 0, 0);
    send_frame(8'h30, 1, 0, 0);
    tick();
    check("parity_out", out_interface, 32'h30201003);
`endif

    // Randomized frames with occasional stop (and parity) errors and gaps
    for (int n = 0; n < 200; n++) begin
      logic [7:0] d;
      int         kind;
      bit         pb;
      d    = 8'($urandom_range(0, 255));
      kind = int'($urandom_range(0, 7));
      pb   = 1'b0;
`ifdef UART_RX_PARITY_EN
      pb = (kind == 1);
`endif
      send_frame(d, kind != 0, pb, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 5)) tick();
    end

    repeat (30 * CLK_DIV) tick();
    check("words_drained", 32'(exp_words.size()), 32'h0);
    check("errs_drained", 32'(exp_err), 32'h0);
    check("out_stability", 32'(stab_viol), 32'h0);
    check("valid_ferr_exclusive", 32'(both_viol), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
